// File: rtl/wb_register_file.sv
// rtl/wb_register_file.sv - write-back stage register file with MemToReg select and same-cycle bypass
// 32 GPRs, r0 hardwired to zero, two bypassed ID read ports, one raw debug port, retired-write counter.
module wb_register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              RegWrite_i,
    input  logic              MemToReg_i,
    input  logic [DATA_W-1:0] ReadData_i,
    input  logic [DATA_W-1:0] ALUResult_i,
    input  logic [ADDR_W-1:0] RegDst_i,
    input  logic [ADDR_W-1:0] RSaddr_i,
    input  logic [ADDR_W-1:0] RTaddr_i,
    input  logic [ADDR_W-1:0] DbgAddr_i,
    output logic [DATA_W-1:0] RSdata_o,
    output logic [DATA_W-1:0] RTdata_o,
    output logic [DATA_W-1:0] DbgData_o,
    output logic [DATA_W-1:0] WBdata_o,
    output logic [CNT_W-1:0]  WBcount_o
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [DATA_W-1:0] wb_data;
    logic              commit_en;
    logic [NREG-1:0]   wr_sel;
    logic              rs_bypass;
    logic              rt_bypass;
    logic [DATA_W-1:0] rs_array;
    logic [DATA_W-1:0] rt_array;

    assign wb_data   = MemToReg_i ? ReadData_i : ALUResult_i;
    assign commit_en = RegWrite_i && (RegDst_i != '0);

    // Decode is gated by RegWrite_i first, so X on the data/index inputs of a bubble cannot select a register.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NREG; i++) begin
            wr_sel[i] = commit_en && (RegDst_i == ADDR_W'(i));
        end
    end

    always_comb begin
        count_d = count_q;
        if (commit_en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_sel[i]) begin
                    regs_q[i] <= wb_data;
                end
            end
            count_q <= count_d;
        end
    end

    always_comb begin
        rs_array  = (RSaddr_i == '0)  ? '0 : regs_q[RSaddr_i];
        rt_array  = (RTaddr_i == '0)  ? '0 : regs_q[RTaddr_i];
        DbgData_o = (DbgAddr_i == '0) ? '0 : regs_q[DbgAddr_i];
    end

    // Bypass is masked during reset so a pending write cannot leak onto the read ports.
    assign rs_bypass = rst_n_i && commit_en && (RSaddr_i == RegDst_i);
    assign rt_bypass = rst_n_i && commit_en && (RTaddr_i == RegDst_i);

    assign RSdata_o  = rs_bypass ? wb_data : rs_array;
    assign RTdata_o  = rt_bypass ? wb_data : rt_array;
    assign WBdata_o  = wb_data;
    assign WBcount_o = count_q;

endmodule

// File: tb/tb_wb_register_file.sv
// tb/tb_wb_register_file.sv - directed self-checking bench for wb_register_file
module tb_wb_register_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0]  reg_dst;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  dbg_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] dbg_data;
    logic [31:0] wb_data;
    logic [31:0] wb_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_register_file #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .RegWrite_i  (reg_write),
        .MemToReg_i  (mem_to_reg),
        .ReadData_i  (read_data),
        .ALUResult_i (alu_result),
        .RegDst_i    (reg_dst),
        .RSaddr_i    (rs_addr),
        .RTaddr_i    (rt_addr),
        .DbgAddr_i   (dbg_addr),
        .RSdata_o    (rs_data),
        .RTdata_o    (rt_data),
        .DbgData_o   (dbg_data),
        .WBdata_o    (wb_data),
        .WBcount_o   (wb_count)
    );

    task automatic drive(input logic we, input logic m2r, input logic [31:0] rd,
                         input logic [31:0] alu, input logic [4:0] dst,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dbg);
        @(negedge clk);
        reg_write  = we;
        mem_to_reg = m2r;
        read_data  = rd;
        alu_result = alu;
        reg_dst    = dst;
        rs_addr    = rs;
        rt_addr    = rt;
        dbg_addr   = dbg;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        reg_write = 1'b0; mem_to_reg = 1'b0; read_data = '0; alu_result = '0;
        reg_dst = '0; rs_addr = '0; rt_addr = '0; dbg_addr = '0;
        #1;
        checks++;
        if (wb_count !== 32'd0) begin
            errors++; $display("FAIL reset_count got %h exp %h", wb_count, 32'd0);
        end
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i); rt_addr = 5'(31 - i); dbg_addr = 5'(i);
            #1;
            checks++;
            if (rs_data !== 32'd0 || rt_data !== 32'd0 || dbg_data !== 32'd0) begin
                errors++;
                $display("FAIL reset_read[%0d] rs %h rt %h dbg %h exp 0", i, rs_data, rt_data, dbg_data);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rtype();
        drive(1'b1, 1'b0, 32'h0000_0055, 32'h0000_1234, 5'd5, 5'd5, 5'd6, 5'd5);
        checks++;
        if (rs_data !== 32'h0000_1234) begin
            errors++; $display("FAIL rtype_bypass got %h exp %h", rs_data, 32'h1234);
        end
        checks++;
        if (rt_data !== 32'd0 || dbg_data !== 32'd0) begin
            errors++; $display("FAIL rtype_precommit rt %h dbg %h exp 0", rt_data, dbg_data);
        end
        @(posedge clk); #1;
        checks++;
        if (dbg_data !== 32'h0000_1234) begin
            errors++; $display("FAIL rtype_commit got %h exp %h", dbg_data, 32'h1234);
        end
        checks++;
        if (wb_count !== 32'd1) begin
            errors++; $display("FAIL rtype_count got %0d exp 1", wb_count);
        end
    endtask

    task automatic test_load();
        drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0040, 5'd31, 5'd31, 5'd0, 5'd31);
        checks++;
        if (wb_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL load_wbdata got %h exp %h", wb_data, 32'hDEADBEEF);
        end
        checks++;
        if (rs_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL load_bypass got %h exp %h", rs_data, 32'hDEADBEEF);
        end
        @(posedge clk); #1;
        checks++;
        if (dbg_data !== 32'hDEAD_BEEF || wb_count !== 32'd2) begin
            errors++; $display("FAIL load_commit dbg %h cnt %0d exp deadbeef 2", dbg_data, wb_count);
        end
    endtask

    task automatic test_r0();
        drive(1'b1, 1'b0, 32'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
            errors++; $display("FAIL r0_same_cycle rs %h rt %h exp 0", rs_data, rt_data);
        end
        checks++;
        if (wb_data !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL r0_wbdata got %h exp ffffffff", wb_data);
        end
        @(posedge clk); #1;
        checks++;
        if (rs_data !== 32'd0 || dbg_data !== 32'd0 || wb_count !== 32'd2) begin
            errors++; $display("FAIL r0_after rs %h dbg %h cnt %0d exp 0 0 2", rs_data, dbg_data, wb_count);
        end
    endtask

    task automatic test_bubble();
        drive(1'b0, 1'b0, 32'd0, 32'h0000_9999, 5'd5, 5'd5, 5'd5, 5'd5);
        checks++;
        if (rs_data !== 32'h0000_1234 || rt_data !== 32'h0000_1234) begin
            errors++; $display("FAIL bubble_read rs %h rt %h exp 1234", rs_data, rt_data);
        end
        @(posedge clk); #1;
        checks++;
        if (dbg_data !== 32'h0000_1234 || wb_count !== 32'd2) begin
            errors++; $display("FAIL bubble_state dbg %h cnt %0d exp 1234 2", dbg_data, wb_count);
        end
    endtask

    task automatic test_dual_bypass();
        drive(1'b1, 1'b0, 32'd0, 32'h0000_00A5, 5'd7, 5'd7, 5'd7, 5'd7);
        checks++;
        if (rs_data !== 32'h0000_00A5 || rt_data !== 32'h0000_00A5) begin
            errors++; $display("FAIL dual_bypass rs %h rt %h exp a5", rs_data, rt_data);
        end
        @(posedge clk); #1;
        checks++;
        if (dbg_data !== 32'h0000_00A5 || wb_count !== 32'd3) begin
            errors++; $display("FAIL dual_commit dbg %h cnt %0d exp a5 3", dbg_data, wb_count);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 32'd0, 32'h0000_005A, 5'd7, 5'd7, 5'd7, 5'd7);
        checks++;
        if (rs_data !== 32'h0000_005A || rt_data !== 32'h0000_005A) begin
            errors++; $display("FAIL b2b_bypass rs %h rt %h exp 5a", rs_data, rt_data);
        end
        checks++;
        if (dbg_data !== 32'h0000_00A5) begin
            errors++; $display("FAIL b2b_old got %h exp a5", dbg_data);
        end
        @(posedge clk); #1;
        checks++;
        if (dbg_data !== 32'h0000_005A || wb_count !== 32'd4) begin
            errors++; $display("FAIL b2b_commit dbg %h cnt %0d exp 5a 4", dbg_data, wb_count);
        end
    endtask

    task automatic test_x_inputs();
        drive(1'b0, 1'bx, 32'hx, 32'hx, 5'hx, 5'hx, 5'hx, 5'd5);
        @(posedge clk); @(posedge clk); #1;
        dbg_addr = 5'd5; #1;
        checks++;
        if (dbg_data !== 32'h0000_1234) begin
            errors++; $display("FAIL xin_r5 got %h exp 1234", dbg_data);
        end
        dbg_addr = 5'd31; #1;
        checks++;
        if (dbg_data !== 32'hDEAD_BEEF || wb_count !== 32'd4) begin
            errors++; $display("FAIL xin_r31 dbg %h cnt %0d exp deadbeef 4", dbg_data, wb_count);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 32'd0, 32'h0000_0777, 5'd5, 5'd5, 5'd5, 5'd5);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rs_data !== 32'd0 || rt_data !== 32'd0 || wb_count !== 32'd0) begin
            errors++; $display("FAIL areset_now rs %h rt %h cnt %0d exp 0", rs_data, rt_data, wb_count);
        end
        for (int i = 0; i < 32; i += 3) begin
            dbg_addr = 5'(i); rt_addr = 5'(i); #1;
            checks++;
            if (dbg_data !== 32'd0 || rt_data !== 32'd0) begin
                errors++; $display("FAIL areset_read[%0d] dbg %h rt %h exp 0", i, dbg_data, rt_data);
            end
        end
        @(posedge clk);
        @(negedge clk);
        reg_write = 1'b0;
        rst_n = 1'b1;
        dbg_addr = 5'd5;
        #1;
        checks++;
        if (dbg_data !== 32'd0 || wb_count !== 32'd0) begin
            errors++; $display("FAIL areset_abort dbg %h cnt %0d exp 0 0", dbg_data, wb_count);
        end
        drive(1'b1, 1'b1, 32'h0BAD_F00D, 32'd0, 5'd3, 5'd3, 5'd5, 5'd3);
        @(posedge clk); #1;
        checks++;
        if (dbg_data !== 32'h0BAD_F00D || wb_count !== 32'd1) begin
            errors++; $display("FAIL areset_resume dbg %h cnt %0d exp 0badf00d 1", dbg_data, wb_count);
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load();
        test_r0();
        test_bubble();
        test_dual_bypass();
        test_back_to_back();
        test_x_inputs();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
